// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
// Shared types and constants for the clock datapath.
//   bcd_t          : one BCD digit (4 bits)
//   HORA_MAX_MSD   : tens digit of the last hour of the day (2)
//   HORA_MAX_LSD   : units digit of the last hour of the day (3)
//   HORA_MEIO_DIA  : first afternoon hour, in binary (12)
//   hour_op_t      : operation applied to the hour register in a cycle
//   bcd_hour_legal : legality check for a 24h BCD hour pair
//   bcd_hour_bin   : 24h BCD hour pair to binary (valid for legal pairs only)
// -----------------------------------------------------------------------------
package clock_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t       HORA_MAX_MSD  = 4'd2;
    localparam bcd_t       HORA_MAX_LSD  = 4'd3;
    localparam logic [4:0] HORA_MEIO_DIA = 5'd12;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_INC  = 2'd1,
        OP_DEC  = 2'd2,
        OP_FIX  = 2'd3
    } hour_op_t;

    // A legal hour has tens 0..2, units 0..9, and units 0..3 when tens is 2.
    function automatic logic bcd_hour_legal(input bcd_t msd, input bcd_t lsd);
        logic ok;
        ok = 1'b1;
        if (msd > HORA_MAX_MSD) begin
            ok = 1'b0;
        end else if (lsd > 4'd9) begin
            ok = 1'b0;
        end else if ((msd == HORA_MAX_MSD) && (lsd > HORA_MAX_LSD)) begin
            ok = 1'b0;
        end else begin
            ok = 1'b1;
        end
        return ok;
    endfunction

    // Only the low two bits of the tens digit matter for a legal hour.
    function automatic logic [4:0] bcd_hour_bin(input bcd_t msd, input bcd_t lsd);
        return ({3'b000, msd[1:0]} * 5'd10) + {1'b0, lsd};
    endfunction

endpackage

// File: rtl/conv_12h.sv
// -----------------------------------------------------------------------------
// conv_12h
// Purely combinational 24h -> 12h hour conversion.
//   i_msd : 24h tens digit (BCD, 0..2)
//   i_lsd : 24h units digit (BCD, 0..9)
//   o_msd : 12h tens digit (0..1)
//   o_lsd : 12h units digit (BCD)
//   o_pm  : 1 when the 24h hour is 12..23
// Midnight (00) maps to 12, afternoon hours 13..23 map to 01..11.
// -----------------------------------------------------------------------------
module conv_12h
    import clock_pkg::*;
(
    input  bcd_t       i_msd,
    input  bcd_t       i_lsd,
    output logic [1:0] o_msd,
    output bcd_t       o_lsd,
    output logic       o_pm
);

    logic [4:0] w_bin;
    logic [4:0] w_h12;

    // Convert to binary, fold into the 1..12 range, then back to BCD.
    always_comb begin
        w_bin = bcd_hour_bin(i_msd, i_lsd);
        w_h12 = w_bin;
        o_pm  = 1'b0;
        o_msd = 2'd0;
        o_lsd = 4'd0;

        if (w_bin >= HORA_MEIO_DIA) begin
            o_pm = 1'b1;
        end else begin
            o_pm = 1'b0;
        end

        if (w_bin == 5'd0) begin
            w_h12 = HORA_MEIO_DIA;
        end else if (w_bin > HORA_MEIO_DIA) begin
            w_h12 = w_bin - HORA_MEIO_DIA;
        end else begin
            w_h12 = w_bin;
        end

        // w_h12 is 1..12 here, so a 4-bit subtraction of ten is exact.
        if (w_h12 >= 5'd10) begin
            o_msd = 2'd1;
            o_lsd = w_h12[3:0] - 4'd10;
        end else begin
            o_msd = 2'd0;
            o_lsd = w_h12[3:0];
        end
    end

endmodule

// File: rtl/maq_h.sv
// -----------------------------------------------------------------------------
// maq_h
// Hour counter of a digital clock, kept internally as a 24h BCD pair.
//   maqh_clock         : system clock, rising edge
//   maqh_reset         : asynchronous reset, active low
//   maqh_enable        : count enable; low freezes the hour
//   maqh_incremento    : carry strobe from the minutes counter
//   maqh_ajuste_up     : manual +1 hour strobe
//   maqh_ajuste_down   : manual -1 hour strobe
//   maqh_modo12        : display format, 1 = 12h, 0 = 24h
//   maqh_Lsd           : displayed hour units digit (BCD)
//   maqh_Msd           : displayed hour tens digit (BCD)
//   maqh_pm            : 1 when the internal hour is 12..23
//   maqh_incrementadia : one-cycle day carry after a 23 -> 00 carry wrap
// The display registers follow the internal hour one cycle later and keep
// tracking maqh_modo12 even while counting is disabled.
// -----------------------------------------------------------------------------
module maq_h
    import clock_pkg::*;
(
    input  logic       maqh_clock,
    input  logic       maqh_reset,
    input  logic       maqh_enable,
    input  logic       maqh_incremento,
    input  logic       maqh_ajuste_up,
    input  logic       maqh_ajuste_down,
    input  logic       maqh_modo12,
    output logic [3:0] maqh_Lsd,
    output logic [1:0] maqh_Msd,
    output logic       maqh_pm,
    output logic       maqh_incrementadia
);

    // Internal 24h hour and day-carry register.
    bcd_t       r_hr_msd;
    bcd_t       r_hr_lsd;
    logic       r_dia;

    // Display registers.
    logic [3:0] r_disp_lsd;
    logic [1:0] r_disp_msd;
    logic       r_disp_pm;

    // Combinational next-state terms.
    hour_op_t   w_op;
    logic       w_legal;
    logic       w_at_max;
    logic       w_at_zero;
    bcd_t       w_nxt_msd;
    bcd_t       w_nxt_lsd;
    logic       w_dia_nxt;

    // 12h view of the current hour and the selected display value.
    logic [1:0] w_c12_msd;
    bcd_t       w_c12_lsd;
    logic       w_c12_pm;
    logic [1:0] w_disp_msd;
    bcd_t       w_disp_lsd;

    assign w_legal   = bcd_hour_legal(r_hr_msd, r_hr_lsd);
    assign w_at_max  = (r_hr_msd == HORA_MAX_MSD) && (r_hr_lsd == HORA_MAX_LSD);
    assign w_at_zero = (r_hr_msd == 4'd0) && (r_hr_lsd == 4'd0);

    // Select this cycle's operation; illegal contents override every request.
    always_comb begin
        w_op = OP_NONE;
        if (!maqh_enable) begin
            w_op = OP_NONE;
        end else if (!w_legal) begin
            w_op = OP_FIX;
        end else if (maqh_incremento) begin
            // A simultaneous ajuste_up is absorbed: still a single step.
            w_op = OP_INC;
        end else if (maqh_ajuste_up ^ maqh_ajuste_down) begin
            w_op = maqh_ajuste_up ? OP_INC : OP_DEC;
        end else begin
            w_op = OP_NONE;
        end
    end

    // Compute the next BCD hour for the selected operation.
    always_comb begin
        w_nxt_msd = r_hr_msd;
        w_nxt_lsd = r_hr_lsd;
        case (w_op)
            OP_INC: begin
                if (w_at_max) begin
                    w_nxt_msd = 4'd0;
                    w_nxt_lsd = 4'd0;
                end else if (r_hr_lsd == 4'd9) begin
                    w_nxt_msd = r_hr_msd + 4'd1;
                    w_nxt_lsd = 4'd0;
                end else begin
                    w_nxt_msd = r_hr_msd;
                    w_nxt_lsd = r_hr_lsd + 4'd1;
                end
            end
            OP_DEC: begin
                if (w_at_zero) begin
                    w_nxt_msd = HORA_MAX_MSD;
                    w_nxt_lsd = HORA_MAX_LSD;
                end else if (r_hr_lsd == 4'd0) begin
                    w_nxt_msd = r_hr_msd - 4'd1;
                    w_nxt_lsd = 4'd9;
                end else begin
                    w_nxt_msd = r_hr_msd;
                    w_nxt_lsd = r_hr_lsd - 4'd1;
                end
            end
            OP_FIX: begin
                w_nxt_msd = 4'd0;
                w_nxt_lsd = 4'd0;
            end
            OP_NONE: begin
                w_nxt_msd = r_hr_msd;
                w_nxt_lsd = r_hr_lsd;
            end
            default: begin
                w_nxt_msd = 4'd0;
                w_nxt_lsd = 4'd0;
            end
        endcase
    end

    // Only a carry-driven wrap from 23 produces a day carry; manual wraps do not.
    assign w_dia_nxt = (w_op == OP_INC) && maqh_incremento && w_at_max;

    conv_12h u_conv_12h (
        .i_msd (r_hr_msd),
        .i_lsd (r_hr_lsd),
        .o_msd (w_c12_msd),
        .o_lsd (w_c12_lsd),
        .o_pm  (w_c12_pm)
    );

    // Choose the display format; the internal hour is never touched by this.
    always_comb begin
        w_disp_msd = r_hr_msd[1:0];
        w_disp_lsd = r_hr_lsd;
        if (maqh_modo12) begin
            w_disp_msd = w_c12_msd;
            w_disp_lsd = w_c12_lsd;
        end else begin
            w_disp_msd = r_hr_msd[1:0];
            w_disp_lsd = r_hr_lsd;
        end
    end

    // Hour register and day-carry pulse.
    always_ff @(posedge maqh_clock or negedge maqh_reset) begin
        if (!maqh_reset) begin
            r_hr_msd <= 4'd0;
            r_hr_lsd <= 4'd0;
            r_dia    <= 1'b0;
        end else begin
            r_hr_msd <= w_nxt_msd;
            r_hr_lsd <= w_nxt_lsd;
            r_dia    <= w_dia_nxt;
        end
    end

    // Display registers, updated every edge so format changes apply while disabled.
    always_ff @(posedge maqh_clock or negedge maqh_reset) begin
        if (!maqh_reset) begin
            r_disp_msd <= 2'd0;
            r_disp_lsd <= 4'd0;
            r_disp_pm  <= 1'b0;
        end else begin
            r_disp_msd <= w_disp_msd;
            r_disp_lsd <= w_disp_lsd;
            r_disp_pm  <= w_c12_pm;
        end
    end

    assign maqh_Lsd           = r_disp_lsd;
    assign maqh_Msd           = r_disp_msd;
    assign maqh_pm            = r_disp_pm;
    assign maqh_incrementadia = r_dia;

endmodule

// File: tb/tb_maq_h.sv
// -----------------------------------------------------------------------------
// tb_maq_h
// Directed self-checking bench for maq_h.
// -----------------------------------------------------------------------------
module tb_maq_h;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       inc;
    logic       up;
    logic       dn;
    logic       m12;
    logic [3:0] lsd;
    logic [1:0] msd;
    logic       pm;
    logic       dia;

    int n_cmp;
    int n_err;

    maq_h dut (
        .maqh_clock         (clk),
        .maqh_reset         (rst_n),
        .maqh_enable        (en),
        .maqh_incremento    (inc),
        .maqh_ajuste_up     (up),
        .maqh_ajuste_down   (dn),
        .maqh_modo12        (m12),
        .maqh_Lsd           (lsd),
        .maqh_Msd           (msd),
        .maqh_pm            (pm),
        .maqh_incrementadia (dia)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp = n_cmp + 1;
        assert (obs === exp) else begin
            n_err = n_err + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_disp(input string tag, input int e_msd, input int e_lsd, input int e_pm);
        chk({tag, " msd"}, {6'd0, msd}, 8'(e_msd));
        chk({tag, " lsd"}, {4'd0, lsd}, 8'(e_lsd));
        chk({tag, " pm"},  {7'd0, pm},  8'(e_pm));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One strobe cycle: day carry is checked after the hour edge, then one
    // more edge lets the display catch up.
    task automatic step(input logic s_inc, input logic s_up, input logic s_dn,
                        input logic exp_dia, input string tag);
        inc = s_inc;
        up  = s_up;
        dn  = s_dn;
        tick();
        inc = 1'b0;
        up  = 1'b0;
        dn  = 1'b0;
        chk({tag, " dia"}, {7'd0, dia}, {7'd0, exp_dia});
        tick();
    endtask

    initial begin
        int h;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        en    = 1'b1;
        inc   = 1'b0;
        up    = 1'b0;
        dn    = 1'b0;
        m12   = 1'b1;

        // Reset state while held in reset.
        #12;
        chk_disp("in_reset", 0, 0, 0);
        chk("in_reset dia", {7'd0, dia}, 8'd0);

        // First edge after release: 12 in 12h mode, then 00 in 24h mode.
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk_disp("rel_12h", 1, 2, 0);
        chk("rel dia", {7'd0, dia}, 8'd0);
        m12 = 1'b0;
        tick();
        chk_disp("rel_24h", 0, 0, 0);

        // 24 carry pulses: 01..23, 00 with a single day carry on the wrap.
        for (int i = 1; i <= 24; i++) begin
            step(1'b1, 1'b0, 1'b0, (i == 24), $sformatf("inc%0d", i));
            h = i % 24;
            chk_disp($sformatf("inc%0d", i), h / 10, h % 10, (h >= 12) ? 1 : 0);
        end
        chk("after_wrap dia", {7'd0, dia}, 8'd0);

        // Manual wraps never produce a day carry.
        step(1'b0, 1'b0, 1'b1, 1'b0, "dn_00_23");
        chk_disp("dn_00_23", 2, 3, 1);
        step(1'b0, 1'b1, 1'b0, 1'b0, "up_23_00");
        chk_disp("up_23_00", 0, 0, 0);

        // 12h display sequence 23, 00, 01, 12, 13.
        step(1'b0, 1'b0, 1'b1, 1'b0, "to23");
        m12 = 1'b1;
        tick();
        chk_disp("m12_23", 1, 1, 1);
        step(1'b0, 1'b1, 1'b0, 1'b0, "m12_00");
        chk_disp("m12_00", 1, 2, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0, "m12_01");
        chk_disp("m12_01", 0, 1, 0);
        for (int i = 0; i < 11; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, "up_to12");
        end
        chk_disp("m12_12", 1, 2, 1);
        step(1'b0, 1'b1, 1'b0, 1'b0, "m12_13");
        chk_disp("m12_13", 0, 1, 1);

        // Format change while disabled still reaches the display.
        en  = 1'b0;
        m12 = 1'b0;
        tick();
        chk_disp("dis_fmt_13", 1, 3, 1);
        en = 1'b1;

        // Carry and up together at 09 advance one hour only.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, "dn_to09");
        end
        chk_disp("at09", 0, 9, 0);
        step(1'b1, 1'b1, 1'b0, 1'b0, "inc_up_09");
        chk_disp("inc_up_09", 1, 0, 0);

        // Up and down together at 05 leave the hour unchanged.
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, "dn_to05");
        end
        chk_disp("at05", 0, 5, 0);
        step(1'b0, 1'b1, 1'b1, 1'b0, "up_dn_05");
        chk_disp("up_dn_05", 0, 5, 0);

        // Disabled carry pulses at 23 are ignored.
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, "dn_to23");
        end
        chk_disp("at23", 2, 3, 1);
        en  = 1'b0;
        inc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("dis_inc%0d dia", i), {7'd0, dia}, 8'd0);
        end
        inc = 1'b0;
        tick();
        chk_disp("dis_inc_23", 2, 3, 1);
        en = 1'b1;

        // Reset in mid-cycle at 23 with carry high: immediate clear, no day carry.
        inc = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk_disp("mid_rst", 0, 0, 0);
        chk("mid_rst dia", {7'd0, dia}, 8'd0);
        tick();
        chk("rst_held dia", {7'd0, dia}, 8'd0);
        inc   = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("rel2 dia", {7'd0, dia}, 8'd0);
        chk_disp("rel2", 0, 0, 0);
        tick();
        chk("rel2b dia", {7'd0, dia}, 8'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, "post_rst_inc");
        chk_disp("post_rst_inc", 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
